freq_gate_scheduler: RTL and testbench
======================================

# freq_gate_scheduler

Measurement sequencer that shares one gated rising-edge counter among `NCH` Pmod input channels. It scans the channels round-robin, timing a programmable gate window for each. It returns each channel's edge count through a valid/ready result port. It sits between the raw Pmod inputs and the display/consumer logic, and replaces a free-running single-channel counter with a scheduled, handshaken multi-channel measurement.

## Interface
- `CLK_HZ`, 100000000, system clock frequency; gate lengths derive from it.
- `NCH`, 2, number of input channels (2..8).
- `CNT_W`, 16, result width.
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `IN`  in  NCH  asynchronous Pmod input signals.
- `start`  in  1  one-cycle request to begin a scan, sampled only in IDLE.
- `cont`  in  1  continuous mode: rescan after the last channel while high.
- `gate_sel`  in  2  gate length: 0 = 1 s, 1 = 100 ms, 2 = 10 ms, 3 = 1 ms; CLK_HZ/10^gate_sel cycles.
- `busy`  out  1  high in any state except IDLE.
- `result`  out  CNT_W  edge count of the finished gate.
- `result_ch`  out  clog2(NCH)  channel index of `result`.
- `result_sel`  out  2  gate_sel used for `result`.
- `overflow`  out  1  count saturated during that gate.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.

## Operation
- Each `IN` bit passes through a 2-flop synchronizer. The selected synchronized bit feeds an edge-history flop. An edge is counted when the synchronized bit is 1 and the history bit is 0.
- FSM states:
  - IDLE → SETTLE on `start`. Latch `gate_sel` and set ch = 0.
  - SETTLE: 3 cycles. The history flop is loaded from the newly selected channel every cycle, so a channel switch never produces an edge. Then go to GATE with the gate timer set to G−1 and the counter cleared.
  - GATE: G cycles. Count qualified edges. The counter saturates at 2^CNT_W−1 and sets sticky `ovf`. When the timer reaches 0, go to HOLD.
  - HOLD: register `result`, `result_ch`, `result_sel` and `overflow`, and assert `result_valid`. Wait for `result_ready`.
  - Leaving HOLD on handshake:
    - If ch < NCH−1: ch+1, then SETTLE.
    - Else, if `cont` = 1: ch = 0, re-latch `gate_sel`, then SETTLE.
    - Else: IDLE.
- Result registers are stable while `result_valid` = 1. No gate runs during HOLD, so no result is dropped or overwritten.
- `gate_sel` changes mid-scan take effect only at the next scan start.
- `start` outside IDLE is ignored. Deasserting `cont` mid-scan finishes the current scan.
- G is computed as a constant per code; width is clog2(CLK_HZ).

## Timing
- Reset values:
  - Outputs: `busy` = 0, `result_valid` = 0, `result` = 0, `result_ch` = 0, `result_sel` = 0, `overflow` = 0.
  - Internals: FSM in IDLE, synchronizers cleared.
- `start` sampled high at edge k: `busy` = 1 from k+1. SETTLE covers cycles k+1..k+3, and GATE covers k+4..k+3+G.
- `result_valid` rises one cycle after the last GATE cycle and is held until a cycle with `result_valid` & `result_ready`.
- Handshake: transfer occurs on a clock edge with both high. `result_valid` drops the next cycle, and SETTLE of the next channel starts that same cycle. `result_ready` held high permanently gives a 1-cycle HOLD.
- Input-to-count latency is 3 cycles (2 sync + history). An edge is counted iff its qualified detection falls inside the G gate cycles.
- Every pulse must be ≥2 CLK high and ≥2 CLK low to count. Narrower pulses are undefined.
- `RST_N` low at any time: immediate return to reset values. A partial count is discarded and no result is emitted.

## Test plan
- CLK_HZ=100000, gate_sel=3 (G=100), `IN`[0] square wave with period 10, `start`, `result_ready`=1 → ch0 `result`=10 ±1, `result_ch`=0, `overflow`=0.
- Same setup, `IN`[1] period 20 → second result has `result_ch`=1 and value 5 ±1, then `busy` falls (`cont`=0).
- `result_ready`=0 for 50 cycles after the first `result_valid` → result stable, no second gate started, second gate begins the cycle after the handshake.
- CNT_W=4, `IN`[0] period 4, G=100 → `result`=15, `overflow`=1.
- `cont`=1 → results repeat ch0, ch1, ch0…; change `gate_sel` 3→2 mid-scan → new `result_sel` appears only from the next ch0 result.
- `IN` toggling constantly when switching channels → no spurious count; `RST_N` pulse mid-GATE → `busy`=0 and `result_valid`=0 immediately, no result until the next `start`.

Source files
------------

// File: rtl/freq_gate_scheduler.sv
// freq_gate_scheduler
//   One gated rising-edge counter is shared by NCH asynchronous input channels.
//   The channels are scanned round-robin. Each channel is measured over a gate
//   window of programmable length, and its edge count is returned on a
//   valid/ready result port.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   IN           NCH asynchronous input signals
//   start        one-cycle scan request, honoured only while idle
//   cont         continuous mode: rescan from channel 0 after the last channel
//   gate_sel     gate length code: 0=1 s, 1=100 ms, 2=10 ms, 3=1 ms
//   busy         high whenever a scan is in progress
//   result       edge count of the finished gate
//   result_ch    channel index that result belongs to
//   result_sel   gate length code used for result
//   overflow     count saturated during that gate
//   result_valid result available
//   result_ready consumer accepts the result
//
// Result handshake: a transfer happens on a rising CLK edge where result_valid
// and result_ready are both high. result_valid stays high, and result,
// result_ch, result_sel and overflow stay stable, until that transfer. The
// next gate is never started while a result is pending, so results are never
// dropped or overwritten.
//
// The FSM state is available as the 'state' signal, and the enum type
// fgs_state_t names its values.
module freq_gate_scheduler #(
    parameter int CLK_HZ = 100000000,
    parameter int NCH    = 2,
    parameter int CNT_W  = 16,
    localparam int CH_W  = $clog2(NCH),
    localparam int TW    = $clog2(CLK_HZ)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NCH-1:0]   IN,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       gate_sel,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic [CH_W-1:0]  result_ch,
    output logic [1:0]       result_sel,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);

    // Gate lengths in CLK cycles, one per gate_sel code.
    localparam int G0 = CLK_HZ;
    localparam int G1 = CLK_HZ / 10;
    localparam int G2 = CLK_HZ / 100;
    localparam int G3 = CLK_HZ / 1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        HOLD   = 2'd3
    } fgs_state_t;

    fgs_state_t       state;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic             hist;
    logic [CH_W-1:0]  ch;
    logic [1:0]       sel_q;
    logic [1:0]       settle_cnt;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             sel_bit;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             last_ch;

    // The timer is loaded with G-1 and counts down to 0, which gives G gate cycles.
    function automatic logic [TW-1:0] gate_last(input logic [1:0] s);
        logic [TW-1:0] v;
        case (s)
            2'd0:    v = TW'(G0 - 1);
            2'd1:    v = TW'(G1 - 1);
            2'd2:    v = TW'(G2 - 1);
            default: v = TW'(G3 - 1);
        endcase
        return v;
    endfunction

    assign sel_bit  = sync2[ch];
    // A rising edge is seen when the synchronized bit is high and the history bit is low.
    assign edge_det = sel_bit & ~hist;
    assign last_ch  = (ch == CH_W'(NCH - 1));

    // Saturating count. ovf is sticky for the rest of the gate.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (edge_det) begin
            if (cnt == '1) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            sync1        <= '0;
            sync2        <= '0;
            hist         <= 1'b0;
            ch           <= '0;
            sel_q        <= 2'd0;
            settle_cnt   <= 2'd0;
            timer        <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_ch    <= '0;
            result_sel   <= 2'd0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            sync1 <= IN;
            sync2 <= sync1;
            // The history bit follows the selected channel every cycle. After a
            // channel switch it realigns during SETTLE, long before counting
            // starts, so the switch is never counted as an edge.
            hist  <= sel_bit;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        sel_q      <= gate_sel;
                        ch         <= '0;
                        settle_cnt <= 2'd2;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 2'd0) begin
                        state <= GATE;
                        timer <= gate_last(sel_q);
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 2'd1;
                    end
                end

                GATE: begin
                    cnt <= cnt_nxt;
                    ovf <= ovf_nxt;
                    if (timer == '0) begin
                        // Use the next-count values so an edge seen in the last gate cycle is included.
                        state        <= HOLD;
                        result       <= cnt_nxt;
                        overflow     <= ovf_nxt;
                        result_ch    <= ch;
                        result_sel   <= sel_q;
                        result_valid <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        settle_cnt   <= 2'd2;
                        if (!last_ch) begin
                            ch    <= ch + CH_W'(1);
                            state <= SETTLE;
                        end else if (cont) begin
                            ch    <= '0;
                            sel_q <= gate_sel;
                            state <= SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_scheduler.sv
// Directed bench for freq_gate_scheduler with CLK_HZ=100000, so gate_sel=3
// gives G=100 and gate_sel=2 gives G=1000. A second instance with CNT_W=4
// shares all inputs and is checked for saturation.
module tb_freq_gate_scheduler;

    localparam int CLK_HZ = 100000;
    localparam int NCH    = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [1:0]  in_sig = 2'b00;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  gate_sel = 2'd3;
    logic        result_ready = 1'b0;

    logic        busy;
    logic [15:0] result;
    logic [0:0]  result_ch;
    logic [1:0]  result_sel;
    logic        overflow;
    logic        result_valid;

    logic        s_busy;
    logic [3:0]  s_result;
    logic [0:0]  s_result_ch;
    logic [1:0]  s_result_sel;
    logic        s_overflow;
    logic        s_result_valid;

    int checks = 0;
    int errors = 0;

    // Input wave control. half*=0 holds the channel at lvl*. Otherwise the
    // channel toggles every half* cycles.
    int   half0 = 0;
    int   half1 = 0;
    logic lvl0 = 1'b0;
    logic lvl1 = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    freq_gate_scheduler #(.CLK_HZ(CLK_HZ), .NCH(NCH), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN(in_sig), .start(start), .cont(cont),
        .gate_sel(gate_sel), .busy(busy), .result(result), .result_ch(result_ch),
        .result_sel(result_sel), .overflow(overflow), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    freq_gate_scheduler #(.CLK_HZ(CLK_HZ), .NCH(NCH), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .IN(in_sig), .start(start), .cont(cont),
        .gate_sel(gate_sel), .busy(s_busy), .result(s_result), .result_ch(s_result_ch),
        .result_sel(s_result_sel), .overflow(s_overflow), .result_valid(s_result_valid),
        .result_ready(result_ready)
    );

    // Input wave generator, changing on the falling edge.
    initial begin
        int pc0;
        int pc1;
        pc0 = 0;
        pc1 = 0;
        forever begin
            @(negedge CLK);
            if (half0 == 0) begin
                in_sig[0] = lvl0;
                pc0 = 0;
            end else begin
                pc0++;
                if (pc0 >= half0) begin
                    pc0 = 0;
                    in_sig[0] = ~in_sig[0];
                end
            end
            if (half1 == 0) begin
                in_sig[1] = lvl1;
                pc1 = 0;
            end else begin
                pc1++;
                if (pc1 >= half1) begin
                    pc1 = 0;
                    in_sig[1] = ~in_sig[1];
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Assert start for exactly one sampling edge and return 1 ns after that edge.
    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // n = number of edges until result_valid is seen, including that edge.
    task automatic wait_valid(input int budget, output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         n;
        logic       ok;
        logic [15:0] r_hold;
        logic       stable;
        logic       seen;

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_ch", result_ch, 0);
        check("rst_sel", result_sel, 0);
        check("rst_ovf", overflow, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // A: single scan, IN[0] period 10, IN[1] period 20, G=100, ready held high
        gate_sel = 2'd3;
        half0 = 5;
        half1 = 10;
        result_ready = 1'b1;
        cont = 1'b0;
        repeat (5) step();
        pulse_start();
        check("a_busy_after_start", busy, 1);
        wait_valid(300, n, ok);
        check("a_ch0_seen", ok, 1);
        check("a_ch0_latency", n, 103);
        check_rng("a_ch0_count", result, 9, 11);
        check("a_ch0_ch", result_ch, 0);
        check("a_ch0_sel", result_sel, 3);
        check("a_ch0_ovf", overflow, 0);
        wait_valid(300, n, ok);
        check("a_ch1_seen", ok, 1);
        check("a_ch1_latency", n, 104);
        check_rng("a_ch1_count", result, 4, 6);
        check("a_ch1_ch", result_ch, 1);
        check("a_ch1_sel", result_sel, 3);
        step();
        check("a_end_valid", result_valid, 0);
        check("a_end_busy", busy, 0);

        // B: consumer stalls for 50 cycles, and a start during HOLD is ignored
        result_ready = 1'b0;
        repeat (3) step();
        pulse_start();
        wait_valid(300, n, ok);
        check("b_ch0_seen", ok, 1);
        check("b_ch0_latency", n, 103);
        r_hold = result;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (result_valid !== 1'b1 || result !== r_hold || result_ch !== 1'b0)
                stable = 1'b0;
            start = (i == 20);
        end
        start = 1'b0;
        check("b_stall_stable", stable, 1);
        result_ready = 1'b1;
        step();
        check("b_hs_valid_drop", result_valid, 0);
        check("b_hs_busy", busy, 1);
        wait_valid(300, n, ok);
        check("b_ch1_latency", n, 103);
        check("b_ch1_ch", result_ch, 1);
        step();
        check("b_end_busy", busy, 0);

        // C: saturation on the 4-bit instance. IN[1] is held high while IN[0] toggles across the switch.
        half0 = 2;
        half1 = 0;
        lvl1  = 1'b1;
        repeat (5) step();
        pulse_start();
        wait_valid(300, n, ok);
        check("c_ch0_latency", n, 103);
        check_rng("c_wide_count", result, 24, 26);
        check("c_wide_ovf", overflow, 0);
        check("c_sat_valid", s_result_valid, 1);
        check("c_sat_count", s_result, 15);
        check("c_sat_ovf", s_overflow, 1);
        wait_valid(300, n, ok);
        check("c_ch1_ch", result_ch, 1);
        check("c_ch1_no_spurious", result, 0);
        check("c_ch1_ovf", overflow, 0);
        check("c_sat_ch1_count", s_result, 0);
        check("c_sat_ch1_ovf_cleared", s_overflow, 0);
        step();

        // D: continuous mode. A gate_sel change mid-scan applies from the next ch0 result.
        half0 = 5;
        half1 = 10;
        cont  = 1'b1;
        gate_sel = 2'd3;
        repeat (3) step();
        pulse_start();
        wait_valid(300, n, ok);
        check("d_r0_ch", result_ch, 0);
        check("d_r0_sel", result_sel, 3);
        check_rng("d_r0_count", result, 9, 11);
        gate_sel = 2'd2;
        wait_valid(300, n, ok);
        check("d_r1_ch", result_ch, 1);
        check("d_r1_sel", result_sel, 3);
        check_rng("d_r1_count", result, 4, 6);
        wait_valid(1300, n, ok);
        check("d_r2_seen", ok, 1);
        check("d_r2_latency", n, 1004);
        check("d_r2_ch", result_ch, 0);
        check("d_r2_sel", result_sel, 2);
        check_rng("d_r2_count", result, 99, 101);
        cont = 1'b0;
        wait_valid(1300, n, ok);
        check("d_r3_ch", result_ch, 1);
        check("d_r3_sel", result_sel, 2);
        check_rng("d_r3_count", result, 49, 51);
        step();
        check("d_end_busy", busy, 0);

        // F: reset mid-gate discards the partial count
        gate_sel = 2'd3;
        repeat (3) step();
        pulse_start();
        repeat (50) step();
        #2;
        RST_N = 1'b0;
        #1;
        check("f_rst_busy", busy, 0);
        check("f_rst_valid", result_valid, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (result_valid !== 1'b0) seen = 1'b1;
        end
        check("f_no_result_after_rst", seen, 0);
        check("f_idle_busy", busy, 0);
        pulse_start();
        wait_valid(300, n, ok);
        check("f_restart_latency", n, 103);
        check("f_restart_ch", result_ch, 0);
        check_rng("f_restart_count", result, 9, 11);
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
